// File: rtl/cpu_run_sequencer.sv
// Run controller for the 10-bit pipelined CPU core.
// It holds the core in reset, releases it on a start request and counts the
// execution cycles. It captures the core result when done rises, aborts the
// run on a cycle-count timeout, and presents the captured result to the host
// through a valid/ack handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | core held in reset, waiting for start
// HOLD  | core still held in reset for RESET_CYCLES clocks after start
// RUN   | core released, cycle counter running, watching done/timeout
// DONE  | core frozen in reset, captured result presented until ack

module cpu_run_sequencer #(
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1000,
    parameter int CNT_W        = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             cpu_done,
    input  logic [9:0]       cpu_result,
    output logic             cpu_reset,
    output logic             busy,
    output logic             result_valid,
    output logic [9:0]       result,
    output logic [CNT_W-1:0] cycles,
    output logic             timed_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Comparisons are made one bit wider than the counter, so counter+1 can
    // reach TIMEOUT = 2^CNT_W-1 without any chance of wrap-around.
    localparam logic [3:0]       HOLD_LAST   = 4'(RESET_CYCLES - 1);
    localparam logic [CNT_W:0]   TIMEOUT_EXT = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    logic [3:0]       hold_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W:0]   run_next;

    // RUN cycle count including the edge currently being sampled.
    assign run_next = {1'b0, run_cnt} + (CNT_W + 1)'(1);

    // Status outputs are decoded straight from the state register, so they
    // change on the same edge as the state.
    assign cpu_reset    = (state != RUN);
    assign busy         = (state == HOLD) || (state == RUN);
    assign result_valid = (state == DONE);

    // Sequencer FSM together with its counters and the captured result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            run_cnt   <= '0;
            result    <= '0;
            cycles    <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= HOLD;
                        hold_cnt  <= '0;
                        result    <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state     <= IDLE;
                        result    <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state   <= RUN;
                        run_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                RUN: begin
                    // Abort beats done, and done beats a timeout on the same edge.
                    if (abort) begin
                        state     <= IDLE;
                        result    <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end else if (cpu_done) begin
                        state     <= DONE;
                        result    <= cpu_result;
                        cycles    <= run_next[CNT_W-1:0];
                        timed_out <= 1'b0;
                    end else if (run_next == TIMEOUT_EXT) begin
                        state     <= DONE;
                        result    <= '0;
                        cycles    <= TIMEOUT_CNT;
                        timed_out <= 1'b1;
                    end else begin
                        run_cnt <= run_next[CNT_W-1:0];
                    end
                end
                DONE: begin
                    if (ack && start) begin
                        state     <= HOLD;
                        hold_cnt  <= '0;
                        result    <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end else if (ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer with randomized run lengths.
module tb_cpu_run_sequencer;

    localparam int RC = 2;
    localparam int TO = 20;
    localparam int CW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          ack;
    logic          cpu_done;
    logic [9:0]    cpu_result;
    logic          cpu_reset;
    logic          busy;
    logic          result_valid;
    logic [9:0]    result;
    logic [CW-1:0] cycles;
    logic          timed_out;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_run_sequencer #(
        .RESET_CYCLES(RC),
        .TIMEOUT     (TO),
        .CNT_W       (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ack         (ack),
        .cpu_done    (cpu_done),
        .cpu_result  (cpu_result),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .cycles      (cycles),
        .timed_out   (timed_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if ({cpu_reset, busy, result_valid, result, cycles, timed_out} !==
            {1'b1, 1'b0, 1'b0, 10'd0, {CW{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: got cpu_reset=%b busy=%b valid=%b result=%h cycles=%0d to=%b, want 1 0 0 000 0 0",
                     tag, cpu_reset, busy, result_valid, result, cycles, timed_out);
        end
    endtask

    // Start pulse followed by the reset-hold phase; ends right after the edge entering RUN.
    task automatic start_run(input bit hold_done);
        start    = 1'b1;
        cpu_done = hold_done;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cpu_reset !== 1'b1 || result_valid !== 1'b0 || cycles !== '0) begin
            n_fail++;
            $display("FAIL start_edge: busy=%b cpu_reset=%b valid=%b cycles=%0d, want 1 1 0 0",
                     busy, cpu_reset, result_valid, cycles);
        end
        for (int h = 1; h < RC; h++) begin
            tick();
            n_checks++;
            if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_%0d: cpu_reset=%b busy=%b, want 1 1", h, cpu_reset, busy);
            end
        end
        tick();
        cpu_done = 1'b0;
        n_checks++;
        if (cpu_reset !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_entry: cpu_reset=%b busy=%b, want 0 1", cpu_reset, busy);
        end
    endtask

    // RUN phase: done asserted on RUN cycle done_at (0 or >TO means never).
    task automatic run_phase(input int done_at, input logic [9:0] res);
        int         end_i;
        logic [9:0] exp_res;
        int         exp_cyc;
        logic       exp_to;
        if (done_at >= 1 && done_at <= TO) begin
            end_i = done_at; exp_cyc = done_at; exp_res = res; exp_to = 1'b0;
        end else begin
            end_i = TO; exp_cyc = TO; exp_res = 10'd0; exp_to = 1'b1;
        end
        for (int i = 1; i <= TO; i++) begin
            cpu_done   = (i == done_at);
            cpu_result = (i == done_at) ? res : 10'($urandom);
            tick();
            if (i < end_i) begin
                n_checks++;
                if (result_valid !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_cycle_%0d: valid=%b cpu_reset=%b busy=%b, want 0 0 1",
                             i, result_valid, cpu_reset, busy);
                end
            end else begin
                n_checks++;
                if (result_valid !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1 ||
                    result !== exp_res || cycles !== CW'(exp_cyc) || timed_out !== exp_to) begin
                    n_fail++;
                    $display("FAIL capture(done_at=%0d): valid=%b busy=%b cpu_reset=%b result=%h cycles=%0d to=%b, want 1 0 1 %h %0d %b",
                             done_at, result_valid, busy, cpu_reset, result, cycles, timed_out,
                             exp_res, exp_cyc, exp_to);
                end
                break;
            end
        end
        cpu_done = 1'b0;
    endtask

    task automatic ack_done();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL ack: valid=%b busy=%b cpu_reset=%b, want 0 0 1", result_valid, busy, cpu_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
        cpu_done = 1'b0; cpu_result = '0;
        tick();
        tick();
        reset = 1'b0;
        check_idle_outputs("reset_state");
        for (int i = 0; i < 3; i++) tick();
        check_idle_outputs("idle_stable");
    endtask

    task automatic test_basic_run();
        start_run(1'b0);
        run_phase(7, 10'h2A1);
        ack_done();
    endtask

    task automatic test_timeout();
        start_run(1'b0);
        run_phase(0, 10'h000);
        tick();
        n_checks++;
        if (cpu_reset !== 1'b1 || result_valid !== 1'b1 || timed_out !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: cpu_reset=%b valid=%b to=%b, want 1 1 1", cpu_reset, result_valid, timed_out);
        end
        ack_done();
    endtask

    task automatic test_done_in_hold();
        start_run(1'b1);
        run_phase(1, 10'h0F3);
        ack_done();
    endtask

    task automatic test_done_at_timeout();
        start_run(1'b0);
        run_phase(TO, 10'h3C5);
        ack_done();
    endtask

    task automatic test_abort_with_done();
        start_run(1'b0);
        tick();
        tick();
        abort = 1'b1; cpu_done = 1'b1; cpu_result = 10'h1AB;
        tick();
        abort = 1'b0; cpu_done = 1'b0;
        check_idle_outputs("abort_with_done");
        for (int i = 0; i < 3; i++) tick();
        check_idle_outputs("after_abort");
    endtask

    task automatic test_done_handshake();
        start_run(1'b0);
        run_phase(4, 10'h155);
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (result_valid !== 1'b1 || busy !== 1'b0 || result !== 10'h155 || cycles !== CW'(4)) begin
            n_fail++;
            $display("FAIL done_ignores_start_abort: valid=%b busy=%b result=%h cycles=%0d, want 1 0 155 4",
                     result_valid, busy, result, cycles);
        end
        ack = 1'b1; start = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1 || cycles !== '0 || result !== '0 ||
            timed_out !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_start: valid=%b busy=%b cycles=%0d result=%h to=%b cpu_reset=%b, want 0 1 0 000 0 1",
                     result_valid, busy, cycles, result, timed_out, cpu_reset);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort_in_hold");
    endtask

    task automatic test_reset_mid_run();
        start_run(1'b0);
        tick();
        tick();
        reset = 1'b1; cpu_done = 1'b1; cpu_result = 10'h3FF;
        tick();
        reset = 1'b0; cpu_done = 1'b0;
        check_idle_outputs("reset_mid_run");
        start_run(1'b0);
        run_phase(5, 10'h2B7);
        ack_done();
    endtask

    task automatic test_random_runs();
        for (int n = 0; n < 10; n++) begin
            int         d;
            logic [9:0] r;
            d = int'($urandom_range(1, TO + 5));
            r = 10'($urandom);
            start_run(1'($urandom_range(0, 1)));
            run_phase(d, r);
            ack_done();
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_timeout();
        test_done_in_hold();
        test_done_at_timeout();
        test_abort_with_done();
        test_done_handshake();
        test_reset_mid_run();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
